alu_seq_acc: RTL

Parametrised, registered successor to the 4-bit combinational lab ALU. Operand A comes from switches. Operand B is the low W bits of an internal result register, so results chain across operations as an accumulator. Single-cycle operations complete in one clock; a compile-time optional shift-add multiplier takes W iteration cycles. The block sits between the switch/key inputs and the HEX/LED display drivers on the DE1 top level.

---
 rtl/alu_seq_acc_if.sv | 22 ++
 rtl/alu_seq_acc.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_acc_if.sv
// Operand/control and result bundle between the switch/key inputs and the
// accumulator ALU; the ALU sits on the slave side.
interface alu_seq_acc_if #(
    parameter int W = 4
);
    logic [W-1:0]   A;
    logic [2:0]     Function;
    logic           start;
    logic [2*W-1:0] ALUout;
    logic           busy;
    logic           done;

    modport master (
        output A, Function, start,
        input  ALUout, busy, done
    );

    modport slave (
        input  A, Function, start,
        output ALUout, busy, done
    );
endinterface

// File: rtl/alu_seq_acc.sv
// Registered accumulator ALU: operand B is the low half of the result register.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier for Function 111.
module alu_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// state | meaning
// S_IDLE | waiting for start; single-cycle ops complete here
// S_MUL  | shift-add iterations in progress, busy high
module alu_seq_acc #(
    parameter int W = 4
) (
    input logic           Clock,
    input logic           Reset_b,
    alu_seq_acc_if.slave  bus
);
    localparam int RW = 2 * W;

    logic [RW-1:0] alu_out_q, alu_out_d;
    logic          done_q, done_d;
    logic [W-1:0]  a_op;
    logic [W-1:0]  b_op;
    logic [2:0]    func;
    logic [W:0]    carry;
    logic [W-1:0]  sum;
    logic [RW-1:0] single_res;

    assign a_op = bus.A;
    assign func = bus.Function;
    assign b_op = alu_out_q[W-1:0];

    assign carry[0] = 1'b0;
    for (genvar i = 0; i < W; i++) begin : g_ripple
        alu_full_adder u_fa (
            .a_i (a_op[i]),
            .b_i (b_op[i]),
            .c_i (carry[i]),
            .s_o (sum[i]),
            .c_o (carry[i+1])
        );
    end

    // Function 111 resolves to zero here; the multiplier path bypasses this mux.
    always_comb begin
        single_res = '0;
        unique case (func)
            3'b000:  single_res = {{(W-1){1'b0}}, carry[W], sum};
            3'b001:  single_res = {{W{1'b0}}, sum};
            3'b010:  single_res = {{W{b_op[W-1]}}, b_op};
            3'b011:  single_res = {{(RW-1){1'b0}}, |{a_op, b_op}};
            3'b100:  single_res = {{(RW-1){1'b0}}, &{a_op, b_op}};
            3'b101:  single_res = {a_op, b_op};
            3'b110:  single_res = {{W{1'b0}}, b_op} << a_op;
            default: single_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] mcand_q, mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [RW-1:0] prod_q, prod_d;
    logic [RW-1:0] prod_step;

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        alu_out_d = alu_out_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (func == 3'b111) begin
                        mcand_d  = {{W{1'b0}}, a_op};
                        mplier_d = b_op;
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        alu_out_d = single_res;
                        done_d    = 1'b1;
                    end
                end
            end
            S_MUL: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    alu_out_d = prod_step;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q == S_MUL);
`else
    always_comb begin
        alu_out_d = alu_out_q;
        done_d    = 1'b0;
        if (bus.start) begin
            alu_out_d = single_res;
            done_d    = 1'b1;
        end
    end

    assign bus.busy = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            alu_out_q <= '0;
            done_q    <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            done_q    <= done_d;
        end
    end

    assign bus.ALUout = alu_out_q;
    assign bus.done   = done_q;
endmodule
